// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and data-width limits.
// Pure declarations, no logic.
// Used by the transmitter today and by the receiver later.
package uart_pkg;

    localparam int UART_MIN_DATA_BITS = 5;
    localparam int UART_MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: emits a one-cycle bit_tick every CLKS_PER_BIT cycles while enabled.
// The tick is combinational from the counter, on the last cycle of each bit period.
// Held at zero while disabled, so the first period after enable is always full length.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_tick = enable && (cnt == LAST);

    // Count 0..CLKS_PER_BIT-1 while enabled, wrap on the tick, park at 0 when disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!enable || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data LSB-first, optional parity, STOP_BITS stop bits.
// Start bit appears on tx the cycle after accept; frame is (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles.
// in_ready only in IDLE and on the tx_done cycle; parity logic is compiled in with UART_TX_PARITY_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    // Elaboration-time guard on parameter legality.
    initial begin
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535)
            $error("uart_tx_frame: CLKS_PER_BIT=%0d out of range 2..65535", CLKS_PER_BIT);
        if (DATA_BITS < UART_MIN_DATA_BITS || DATA_BITS > UART_MAX_DATA_BITS)
            $error("uart_tx_frame: DATA_BITS=%0d out of range", DATA_BITS);
        if (STOP_BITS != 1 && STOP_BITS != 2)
            $error("uart_tx_frame: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
    end

    uart_tx_state_t       state, state_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [CW-1:0]        bit_cnt;
    logic                 bit_tick;
    logic                 last_data;
    logic                 last_stop;
    logic                 done_cyc;
    logic                 accept;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_bit;
`else
    // Parity inputs exist for interface compatibility only.
    logic unused_parity_cfg;
    assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .enable  (state != IDLE),
        .bit_tick(bit_tick)
    );

    assign last_data = (bit_cnt == LAST_DATA);
    assign last_stop = (bit_cnt == LAST_STOP);
    assign done_cyc  = (state == STOP) && bit_tick && last_stop;
    assign in_ready  = (state == IDLE) || done_cyc;
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign tx_done   = done_cyc;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; the tx_done cycle can chain straight into a new START.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = START;
            START: if (bit_tick) state_nxt = DATA;
            DATA: begin
                if (bit_tick && last_data) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = par_en_q ? PARITY : STOP;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_tick) state_nxt = STOP;
`endif
            STOP:  if (done_cyc) state_nxt = accept ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, then update tx and shift on each bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx      <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
`endif
        end else if (accept) begin
            tx      <= 1'b0;
            shreg   <= in_data;
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q <= parity_en;
            par_bit  <= (^in_data) ^ parity_odd;
`endif
        end else if (bit_tick) begin
            case (state)
                START: begin
                    tx    <= shreg[0];
                    shreg <= shreg >> 1;
                end
                DATA: begin
                    if (last_data) begin
                        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        tx <= par_en_q ? par_bit : 1'b1;
`else
                        tx <= 1'b1;
`endif
                    end else begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                PARITY: begin
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                end
                STOP: begin
                    tx <= 1'b1;
                    if (last_stop) bit_cnt <= '0;
                    else           bit_cnt <= bit_cnt + CW'(1);
                end
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: two instances (8N1 and 7N2, 4 clocks per bit).
// Each scenario task drives a frame, records per-cycle outputs and compares them.
// Parity scenarios depend on whether UART_TX_PARITY_EN is defined for the build.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid, in_ready, parity_en, parity_odd, tx, busy, tx_done;
    logic [7:0] in_data;
    logic       in_valid7, in_ready7, tx7, busy7, tx_done7, par_en7, par_odd7;
    logic [6:0] in_data7;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .parity_en(parity_en), .parity_odd(parity_odd),
        .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2)) dut7 (
        .clk(clk), .reset(reset), .in_valid(in_valid7), .in_ready(in_ready7),
        .in_data(in_data7), .parity_en(par_en7), .parity_odd(par_odd7),
        .tx(tx7), .busy(busy7), .tx_done(tx_done7)
    );

    int   sel = 0;
    logic s_tx, s_rdy, s_busy, s_done;
    assign s_tx   = (sel == 1) ? tx7       : tx;
    assign s_rdy  = (sel == 1) ? in_ready7 : in_ready;
    assign s_busy = (sel == 1) ? busy7     : busy;
    assign s_done = (sel == 1) ? tx_done7  : tx_done;

    logic cap_tx   [0:127];
    logic cap_rdy  [0:127];
    logic cap_busy [0:127];
    logic cap_done [0:127];

    // Present a character and wait (bounded) for it to be accepted; returns in cycle 0 of the frame.
    task automatic do_accept(input int s, input logic [7:0] d, input logic pe, input logic po,
                             input bit hold);
        int n;
        if (s == 1) begin
            in_valid7 = 1'b1; in_data7 = d[6:0];
        end else begin
            in_valid = 1'b1; in_data = d; parity_en = pe; parity_odd = po;
        end
        n = 0;
        while (!((s == 1) ? in_ready7 : in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required within 200", n);
        end
        @(posedge clk); #1;
        if (!hold) begin
            in_valid = 1'b0; in_valid7 = 1'b0;
        end
    endtask

    // Record n cycles of outputs; optionally drop in_valid or inject a spurious request.
    task automatic capture(input int n, input int drop_at, input int poke_at);
        for (int c = 0; c < n; c++) begin
            cap_tx[c] = s_tx; cap_rdy[c] = s_rdy; cap_busy[c] = s_busy; cap_done[c] = s_done;
            if (c == drop_at) begin
                in_valid = 1'b0; in_valid7 = 1'b0;
            end
            if (poke_at >= 0 && c == poke_at) begin
                in_valid = 1'b1; in_data = 8'hC3; parity_en = ~parity_en; parity_odd = ~parity_odd;
            end
            if (poke_at >= 0 && c == poke_at + 1) in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (tx_done !== 1'b0)  begin n_fail++; $display("FAIL rst_tx_done: got %b want 0", tx_done); end
        n_checks++; if (tx7 !== 1'b1)      begin n_fail++; $display("FAIL rst_tx7: got %b want 1", tx7); end
        n_checks++; if (in_ready7 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready7: got %b want 1", in_ready7); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_frame_a5();
        logic [0:9] e;
        e = 10'b0101001011;
        do_accept(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        capture(42, -1, -1);
        for (int c = 0; c < 40; c++) begin
            n_checks++;
            if (cap_tx[c] !== e[c/4] || cap_done[c] !== (c == 39) || cap_rdy[c] !== (c == 39)
                || cap_busy[c] !== 1'b1) begin
                n_fail++;
                $display("FAIL a5_frame c%0d: tx/done/rdy/busy=%b%b%b%b want %b%b%b1", c, cap_tx[c],
                         cap_done[c], cap_rdy[c], cap_busy[c], e[c/4], c == 39, c == 39);
            end
        end
        for (int c = 40; c < 42; c++) begin
            n_checks++;
            if (cap_tx[c] !== 1'b1 || cap_done[c] !== 1'b0 || cap_rdy[c] !== 1'b1 || cap_busy[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL a5_idle c%0d: tx/done/rdy/busy=%b%b%b%b want 1010", c, cap_tx[c],
                         cap_done[c], cap_rdy[c], cap_busy[c]);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [0:10] e;
        for (int k = 0; k < 2; k++) begin
            e = (k == 0) ? 11'b01010010101 : 11'b01010010111;
            do_accept(0, 8'hA5, 1'b1, k[0], 1'b0);
            capture(46, -1, -1);
            for (int c = 0; c < 46; c++) begin
                n_checks++;
                if (cap_tx[c] !== ((c < 44) ? e[c/4] : 1'b1) || cap_done[c] !== (c == 43)
                    || cap_busy[c] !== (c < 44)) begin
                    n_fail++;
                    $display("FAIL parity%0d c%0d: tx/done/busy=%b%b%b want %b%b%b", k, c, cap_tx[c],
                             cap_done[c], cap_busy[c], (c < 44) ? e[c/4] : 1'b1, c == 43, c < 44);
                end
            end
        end
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask
`else
    task automatic test_parity();
        logic [0:9] e;
        e = 10'b0101001011;
        do_accept(0, 8'hA5, 1'b1, 1'b1, 1'b0);
        capture(42, -1, -1);
        for (int c = 0; c < 42; c++) begin
            n_checks++;
            if (cap_tx[c] !== ((c < 40) ? e[c/4] : 1'b1) || cap_done[c] !== (c == 39)
                || cap_busy[c] !== (c < 40)) begin
                n_fail++;
                $display("FAIL noparity c%0d: tx/done/busy=%b%b%b want %b%b%b", c, cap_tx[c],
                         cap_done[c], cap_busy[c], (c < 40) ? e[c/4] : 1'b1, c == 39, c < 40);
            end
        end
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [0:9] e0, ef;
        int first_done, second_done, n_done;
        e0 = 10'b0000000001;
        ef = 10'b0111111111;
        do_accept(0, 8'h00, 1'b0, 1'b0, 1'b1);
        in_data = 8'hFF;
        capture(82, 40, -1);
        first_done = -1; second_done = -1; n_done = 0;
        for (int c = 0; c < 82; c++) begin
            logic ex;
            ex = (c < 40) ? e0[c/4] : (c < 80) ? ef[(c-40)/4] : 1'b1;
            n_checks++;
            if (cap_tx[c] !== ex || cap_busy[c] !== (c < 80) || cap_rdy[c] !== (c == 39 || c >= 79)) begin
                n_fail++;
                $display("FAIL b2b c%0d: tx/busy/rdy=%b%b%b want %b%b%b", c, cap_tx[c], cap_busy[c],
                         cap_rdy[c], ex, c < 80, c == 39 || c >= 79);
            end
            if (cap_done[c] === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = c;
                else second_done = c;
            end
        end
        n_checks++;
        if (n_done != 2 || second_done - first_done != 40) begin
            n_fail++;
            $display("FAIL b2b_done: %0d pulses gap %0d, want 2 pulses gap 40", n_done,
                     second_done - first_done);
        end
    endtask

    task automatic test_7bit_2stop();
        logic [0:9] e;
        e = 10'b0100000111;
        sel = 1;
        do_accept(1, 8'h41, 1'b0, 1'b0, 1'b0);
        capture(42, -1, -1);
        for (int c = 0; c < 42; c++) begin
            n_checks++;
            if (cap_tx[c] !== ((c < 40) ? e[c/4] : 1'b1) || cap_done[c] !== (c == 39)
                || cap_busy[c] !== (c < 40)) begin
                n_fail++;
                $display("FAIL d7s2 c%0d: tx/done/busy=%b%b%b want %b%b%b", c, cap_tx[c],
                         cap_done[c], cap_busy[c], (c < 40) ? e[c/4] : 1'b1, c == 39, c < 40);
            end
        end
        sel = 0;
    endtask

    task automatic test_reset_mid_frame();
        logic [0:9] e;
        int n_done;
        e = 10'b0101001011;
        do_accept(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        capture(13, -1, -1);
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_pre_tx: got %b want 0", tx); end
        reset = 1'b1;
        #1;
        n_checks++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_rdy: got %b want 1", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        capture(45, -1, -1);
        n_done = 0;
        for (int c = 0; c < 45; c++) if (cap_done[c] === 1'b1 || cap_busy[c] !== 1'b0) n_done++;
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL mid_no_done: %0d cycles with tx_done/busy after abort, want 0", n_done);
        end
        do_accept(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        capture(40, -1, -1);
        for (int c = 0; c < 40; c++) begin
            n_checks++;
            if (cap_tx[c] !== e[c/4] || cap_done[c] !== (c == 39)) begin
                n_fail++;
                $display("FAIL mid_after c%0d: tx/done=%b%b want %b%b", c, cap_tx[c], cap_done[c],
                         e[c/4], c == 39);
            end
        end
    endtask

    task automatic test_input_hold();
        logic [0:9] e;
        e = 10'b0001111001;
        do_accept(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        capture(50, -1, 10);
        for (int c = 0; c < 50; c++) begin
            n_checks++;
            if (cap_tx[c] !== ((c < 40) ? e[c/4] : 1'b1) || cap_done[c] !== (c == 39)
                || cap_busy[c] !== (c < 40)) begin
                n_fail++;
                $display("FAIL hold c%0d: tx/done/busy=%b%b%b want %b%b%b", c, cap_tx[c],
                         cap_done[c], cap_busy[c], (c < 40) ? e[c/4] : 1'b1, c == 39, c < 40);
            end
        end
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; parity_en = 1'b0; parity_odd = 1'b0;
        in_valid7 = 1'b0; in_data7 = 7'h00; par_en7 = 1'b0; par_odd7 = 1'b0;
        test_reset();
        test_frame_a5();
        test_parity();
        test_back_to_back();
        test_7bit_2stop();
        test_reset_mid_frame();
        test_input_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the fixed 8-bit transmitter in the uart directory. It serialises one character per valid/ready handshake into a standard asynchronous frame: start bit, DATA_BITS data bits LSB-first, optional parity bit, then STOP_BITS stop bits. Bit timing comes from an internal baud divider. It sits between the host-side command/FIFO logic and the tx pad.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  character available on in_data
in_ready  output  1  block can accept a character this cycle
in_data  input  DATA_BITS  character to send; sampled only on accept
parity_en  input  1  insert a parity bit; sampled on accept (see Optional Feature)
parity_odd  input  1  1 = odd parity, 0 = even; sampled on accept
tx  output  1  serial line; idle high
busy  output  1  a frame is in progress
tx_done  output  1  one-cycle pulse on the last cycle of the last stop bit

Behaviour:
- Reset values, applied asynchronously: tx=1, in_ready=1, busy=0, tx_done=0, FSM=IDLE, counters=0.
- Accept: a character is accepted when in_valid & in_ready is high at a rising clk edge.
  - in_data, parity_en and parity_odd are captured into a shift register and config flops.
  - Later changes on these inputs have no effect on the frame in flight.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START -> DATA after one bit period.
  - DATA -> PARITY after DATA_BITS periods if parity is enabled; otherwise DATA -> STOP.
  - PARITY -> STOP after one period.
  - STOP -> IDLE after STOP_BITS periods.
- Latency and timing:
  - tx shows the start bit (0) in the first cycle after the accept edge.
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - tx is registered, with no combinational path from any input.
- Data order: LSB first. The shift register shifts right once per bit period.
- Parity bit = XOR of the captured data, inverted when parity_odd=1.
- Frame length in cycles = (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT, where P = 1 if the parity bit is present, else 0.
- in_ready = 1 in IDLE, and also in the final cycle of the last stop bit (the tx_done cycle). This permits back-to-back frames with zero idle gap.
  - If an accept happens on the tx_done cycle, the next start bit begins on the following cycle.
- busy = 1 from the first start-bit cycle through the tx_done cycle inclusive.
- in_valid while in_ready=0 is ignored. The sender must hold in_valid and in_data until accepted.
- Reset mid-frame: the frame is aborted, tx returns to 1 at once, and no tx_done is issued.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts from 0 to CLKS_PER_BIT-1, wraps to 0, and asserts a one-cycle bit_tick at the wrap. It is held at 0 in IDLE, so the first bit period is always full length.
- Bit counter: width $clog2(DATA_BITS+1). It counts data bits and stop bits and clears on each state change.
- Illegal parameter values are caught by an elaboration-time check in an initial block ($error).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: parity logic is compiled in, and parity_en and parity_odd work as described above.
- Not defined:
  - The ports still exist but are ignored.
  - The PARITY state and the parity XOR tree are removed.
  - Frames never contain a parity bit, so frame length = (1 + DATA_BITS + STOP_BITS) * CLKS_PER_BIT.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum typedef uart_tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - the constants UART_MIN_DATA_BITS=5 and UART_MAX_DATA_BITS=9.
- One sub-module, uart_baud_gen: parameter CLKS_PER_BIT; inputs clk, reset, enable; output bit_tick. The same sub-module will be reused by the future receiver.

Test Plan:
- CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, no parity; send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done pulses 40 cycles after the start bit begins; in_ready is 0 for the whole frame.
- Parity build, same settings, parity_en=1; send 0xA5 with parity_odd=0, then again with parity_odd=1 -> parity bit is 0 and 1 respectively; frame length is 44 cycles.
- Back-to-back: hold in_valid with 0x00 then 0xFF -> the second start bit directly follows the first stop bit with no idle cycle; 2 tx_done pulses exactly 40 cycles apart.
- DATA_BITS=7, STOP_BITS=2; send 0x41 -> tx bits 0,1,0,0,0,0,0,1,1,1; frame length is 40 cycles.
- Assert reset 13 cycles into a frame -> tx=1, busy=0 and in_ready=1 immediately; no tx_done; the next accepted frame is correct.
- Change in_data while busy and pulse in_valid while in_ready=0 -> transmitted bits are unchanged and no extra accept occurs.
